alu_ctrl_exec: RTL
==================

// Module: alu_ctrl_exec
// PURPOSE
//  Parametrised successor to the combinational ALU control decoder. Decodes ALU_OP/funct into a
//  4-bit ALU control code and executes the operation. Adds NOR, shifts, iterative unsigned
//  MULT/DIVU and HI/LO registers. Sits in EX between the ID/EX register and EX/MEM.
//  Uses a valid/ready handshake on both sides; one operation in flight at a time.
// PARAMETERS
//  WIDTH      32  datapath width (>=4, power of 2); SHW = $clog2(WIDTH) is local
//  MULDIV_EN  1   1: mult/divu/mfhi/mflo supported; 0: those functs decode as default (0111)
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       async active-low reset
//  in_valid   in   1       operation request
//  in_ready   out  1       block can accept (state IDLE)
//  alu_op     in   2       00 add, 01 sub, 1x decode funct
//  funct      in   6       R-type function field
//  shamt      in   SHW     shift amount
//  src_a      in   WIDTH   operand A (rs)
//  src_b      in   WIDTH   operand B (rt)
//  out_valid  out  1       result available
//  out_ready  in   1       consumer takes result
//  result     out  WIDTH   registered result
//  zero       out  1       result == 0
//  alu_ctrl   out  4       control code of the op held in result
//  hi, lo     out  WIDTH   HI/LO architectural registers
// BEHAVIOUR
//  Decode: op00->0010 add; op01->0110 sub; op1x by funct: 32->0010 add, 34->0110 sub,
//   36->0000 and, 37->0001 or, 42->0111 slt (signed), 39->1100 nor, 0->1000 sll (b<<shamt),
//   2->1001 srl (b>>shamt, logical), 24->1010 multu, 27->1011 divu, 16->1101 mfhi,
//   18->1110 mflo. Any other funct ->0111 slt (legacy default).
//  Arithmetic: add/sub wrap modulo 2^WIDTH with no overflow flag. slt yields 1 or 0,
//   zero-extended.
//  FSM states: IDLE, MUL, DIV, DONE. in_ready = (state==IDLE).
//  IDLE: on in_valid&&in_ready, latch operands and ctrl.
//   Single-cycle ops: write result, go to DONE. out_valid is high on the cycle after accept.
//   Multu: go to MUL, cnt=0. Shift-add, one bit per cycle, WIDTH cycles.
//    When cnt==WIDTH-1: {hi,lo} <= 2*WIDTH-bit product, result <= lo value, go to DONE.
//    out_valid rises WIDTH+1 cycles after accept.
//   Divu: go to DIV. Restoring division, WIDTH cycles. Then lo<=quotient, hi<=remainder,
//    result <= quotient, go to DONE.
//   Divu by zero: no iteration. lo<=all ones, hi<=src_a, go straight to DONE (latency 1).
//  DONE: out_valid=1. result, zero and alu_ctrl are stable until out_ready.
//   On out_ready: go to IDLE; out_valid drops the next cycle.
//   No new accept occurs while in DONE (no bypass).
//  mfhi/mflo: single-cycle. They read hi/lo as of accept, including a mult/div that
//   completed immediately before.
//  hi/lo change only at mult/div completion.
//  Inputs are ignored outside IDLE; changing them mid-op has no effect.
//  Reset (async, any state, including mid MUL/DIV): state IDLE; result, hi, lo, cnt = 0;
//   out_valid=0; alu_ctrl=0000; zero=1. in_ready=1 while rst_n is low. An aborted op
//   leaves no trace.
//  MULDIV_EN=0: mult/div datapath absent; hi/lo tied to 0.
// TESTING
//  op10 f32 a=5 b=7, accepted at cycle k -> out_valid at k+1, result=12, alu_ctrl=0010,
//   zero=0.
//  f42 a=FFFFFFFF b=1 -> result=1. f39 a=0 b=0 -> result=FFFFFFFF. f0 b=1 shamt=31
//   -> result=80000000.
//  f24 a=FFFFFFFF b=2 -> out_valid at k+33, hi=1, lo=FFFFFFFE; then f18 -> result=FFFFFFFE.
//  f27 a=100 b=7 -> lo=14, hi=2 at k+33. f27 a=9 b=0 -> lo=FFFFFFFF, hi=9 at k+1.
//  Hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0; pulse out_ready
//   -> in_ready=1 next cycle.
//  Assert rst_n=0 at cycle 10 of a multu -> outputs reset immediately, hi=lo=0.
//   After release, op00 3+4 -> result=7.

Source files
------------

// File: rtl/alu_ctrl_exec.sv
// EX-stage ALU with funct decode, single-cycle logic/arith/shift ops and iterative unsigned
// multiply/divide feeding HI/LO; valid/ready on both sides, one operation in flight.
module alu_ctrl_exec #(
   parameter int unsigned WIDTH     = 32,
   parameter bit          MULDIV_EN = 1'b1,
   localparam int unsigned SHW      = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       alu_op,
   input  logic [5:0]       funct,
   input  logic [SHW-1:0]   shamt,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic [3:0]       alu_ctrl,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [3:0] C_AND   = 4'b0000;
   localparam logic [3:0] C_OR    = 4'b0001;
   localparam logic [3:0] C_ADD   = 4'b0010;
   localparam logic [3:0] C_SUB   = 4'b0110;
   localparam logic [3:0] C_SLT   = 4'b0111;
   localparam logic [3:0] C_SLL   = 4'b1000;
   localparam logic [3:0] C_SRL   = 4'b1001;
   localparam logic [3:0] C_MULTU = 4'b1010;
   localparam logic [3:0] C_DIVU  = 4'b1011;
   localparam logic [3:0] C_NOR   = 4'b1100;
   localparam logic [3:0] C_MFHI  = 4'b1101;
   localparam logic [3:0] C_MFLO  = 4'b1110;

   localparam logic [5:0] F_SLL   = 6'd0;
   localparam logic [5:0] F_SRL   = 6'd2;
   localparam logic [5:0] F_MFHI  = 6'd16;
   localparam logic [5:0] F_MFLO  = 6'd18;
   localparam logic [5:0] F_MULTU = 6'd24;
   localparam logic [5:0] F_DIVU  = 6'd27;
   localparam logic [5:0] F_ADD   = 6'd32;
   localparam logic [5:0] F_SUB   = 6'd34;
   localparam logic [5:0] F_AND   = 6'd36;
   localparam logic [5:0] F_OR    = 6'd37;
   localparam logic [5:0] F_NOR   = 6'd39;
   localparam logic [5:0] F_SLT   = 6'd42;

   localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

   logic [1:0]       state, state_nx;
   logic [SHW-1:0]   cnt, cnt_nx;
   logic [WIDTH-1:0] mcand, mcand_nx;
   logic [WIDTH-1:0] acc_hi, acc_hi_nx;
   logic [WIDTH-1:0] acc_lo, acc_lo_nx;
   logic [WIDTH-1:0] result_nx, hi_nx, lo_nx;
   logic [3:0]       ctrl_nx;
   logic             zero_nx, in_ready_nx, out_valid_nx;

   logic [3:0]       dec_ctrl_c;
   logic [WIDTH-1:0] alu_res_c;
   logic [WIDTH:0]   mul_sum_c;
   logic [WIDTH-1:0] mul_hi_c, mul_lo_c;
   logic [WIDTH:0]   div_sh_c, div_diff_c;
   logic [WIDTH-1:0] div_rem_c, div_quo_c;

   // funct decode; mult/div functs fall to the legacy slt default when the unit is absent
   always_comb begin
      dec_ctrl_c = C_SLT;
      if (!alu_op[1]) begin
         dec_ctrl_c = alu_op[0] ? C_SUB : C_ADD;
      end else begin
         case (funct)
            F_ADD:   dec_ctrl_c = C_ADD;
            F_SUB:   dec_ctrl_c = C_SUB;
            F_AND:   dec_ctrl_c = C_AND;
            F_OR:    dec_ctrl_c = C_OR;
            F_SLT:   dec_ctrl_c = C_SLT;
            F_NOR:   dec_ctrl_c = C_NOR;
            F_SLL:   dec_ctrl_c = C_SLL;
            F_SRL:   dec_ctrl_c = C_SRL;
            F_MULTU: dec_ctrl_c = MULDIV_EN ? C_MULTU : C_SLT;
            F_DIVU:  dec_ctrl_c = MULDIV_EN ? C_DIVU : C_SLT;
            F_MFHI:  dec_ctrl_c = MULDIV_EN ? C_MFHI : C_SLT;
            F_MFLO:  dec_ctrl_c = MULDIV_EN ? C_MFLO : C_SLT;
            default: dec_ctrl_c = C_SLT;
         endcase
      end
   end

   // single-cycle result, computed straight from the operands being accepted
   always_comb begin
      alu_res_c = '0;
      case (dec_ctrl_c)
         C_ADD:   alu_res_c = src_a + src_b;
         C_SUB:   alu_res_c = src_a - src_b;
         C_AND:   alu_res_c = src_a & src_b;
         C_OR:    alu_res_c = src_a | src_b;
         C_NOR:   alu_res_c = ~(src_a | src_b);
         C_SLL:   alu_res_c = src_b << shamt;
         C_SRL:   alu_res_c = src_b >> shamt;
         C_MFHI:  alu_res_c = hi;
         C_MFLO:  alu_res_c = lo;
         default: alu_res_c = {{(WIDTH - 1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      endcase
   end

   // one shift-add step: {acc_hi,acc_lo} holds partial product over remaining multiplier bits
   always_comb begin
      mul_sum_c = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
      mul_hi_c  = mul_sum_c[WIDTH:1];
      mul_lo_c  = {mul_sum_c[0], acc_lo[WIDTH-1:1]};
   end

   // one restoring step: acc_hi is the remainder, acc_lo shifts dividend out and quotient in
   always_comb begin
      div_sh_c   = {acc_hi, acc_lo[WIDTH-1]};
      div_diff_c = div_sh_c - {1'b0, mcand};
      if (!div_diff_c[WIDTH]) begin
         div_rem_c = div_diff_c[WIDTH-1:0];
         div_quo_c = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
         div_rem_c = div_sh_c[WIDTH-1:0];
         div_quo_c = {acc_lo[WIDTH-2:0], 1'b0};
      end
   end

   // next-state and registered-output logic
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      mcand_nx  = mcand;
      acc_hi_nx = acc_hi;
      acc_lo_nx = acc_lo;
      result_nx = result;
      ctrl_nx   = alu_ctrl;
      hi_nx     = hi;
      lo_nx     = lo;
      case (state)
         S_IDLE: begin
            if (in_valid) begin
               ctrl_nx = dec_ctrl_c;
               cnt_nx  = '0;
               if (dec_ctrl_c == C_MULTU) begin
                  mcand_nx  = src_a;
                  acc_hi_nx = '0;
                  acc_lo_nx = src_b;
                  state_nx  = S_MUL;
               end else if (dec_ctrl_c == C_DIVU) begin
                  if (src_b == '0) begin
                     lo_nx     = '1;
                     hi_nx     = src_a;
                     result_nx = '1;
                     state_nx  = S_DONE;
                  end else begin
                     mcand_nx  = src_b;
                     acc_hi_nx = '0;
                     acc_lo_nx = src_a;
                     state_nx  = S_DIV;
                  end
               end else begin
                  result_nx = alu_res_c;
                  state_nx  = S_DONE;
               end
            end
         end
         S_MUL: begin
            acc_hi_nx = mul_hi_c;
            acc_lo_nx = mul_lo_c;
            cnt_nx    = cnt + SHW'(1);
            if (cnt == CNT_LAST) begin
               hi_nx     = mul_hi_c;
               lo_nx     = mul_lo_c;
               result_nx = mul_lo_c;
               state_nx  = S_DONE;
            end
         end
         S_DIV: begin
            acc_hi_nx = div_rem_c;
            acc_lo_nx = div_quo_c;
            cnt_nx    = cnt + SHW'(1);
            if (cnt == CNT_LAST) begin
               hi_nx     = div_rem_c;
               lo_nx     = div_quo_c;
               result_nx = div_quo_c;
               state_nx  = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
      zero_nx      = (result_nx == '0);
      in_ready_nx  = (state_nx == S_IDLE);
      out_valid_nx = (state_nx == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         mcand     <= '0;
         acc_hi    <= '0;
         acc_lo    <= '0;
         result    <= '0;
         alu_ctrl  <= '0;
         zero      <= 1'b1;
         hi        <= '0;
         lo        <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         mcand     <= mcand_nx;
         acc_hi    <= acc_hi_nx;
         acc_lo    <= acc_lo_nx;
         result    <= result_nx;
         alu_ctrl  <= ctrl_nx;
         zero      <= zero_nx;
         hi        <= MULDIV_EN ? hi_nx : '0;
         lo        <= MULDIV_EN ? lo_nx : '0;
         in_ready  <= in_ready_nx;
         out_valid <= out_valid_nx;
      end
   end

endmodule
